ccd_clock_generator: RTL and testbench

- Parametrised successor to the fixed-timing CCD phase generator.
- Drives the linear-CCD clocks phi_p, phi_r, phi_l1 and phi_l2, with configurable pixel count, phase stretch and integration timing.
- Adds one-shot/continuous frame modes, registered glitch-free outputs, an ADC sample strobe with pixel index, and busy/frame-done status for the readout controller.

---
 rtl/ccd_gen_pkg.sv | 43 ++++
 rtl/ccd_clock_generator_phase_seq.sv | 77 +++++++
 rtl/ccd_clock_generator.sv | 221 ++++++++++++++++++++++
 tb/tb_ccd_clock_generator.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccd_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ccd_gen_pkg
// Description : Shared types and constants for the linear-CCD clock
//               generator. Holds the FSM state encoding, the quarter-phase
//               encoding and the per-state phase vectors {p, r, l1, l2}.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package ccd_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_HOLD      = 3'd3,
    ST_TRANSFER  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    Q_0 = 2'd0,
    Q_1 = 2'd1,
    Q_2 = 2'd2,
    Q_3 = 2'd3
  } quarter_t;

  // Phase vectors, bit order {phi_p, phi_r, phi_l1, phi_l2}.
  localparam logic [3:0] C_PH_IDLE      = 4'b0000;
  localparam logic [3:0] C_PH_GATE      = 4'b1101;  // PRECHARGE and TRANSFER
  localparam logic [3:0] C_PH_SHIFT_Q0  = 4'b0101;
  localparam logic [3:0] C_PH_SHIFT_Q1  = 4'b0001;
  localparam logic [3:0] C_PH_SHIFT_Q23 = 4'b0010;

  // Phase vector driven during SHIFT for a given quarter.
  function automatic logic [3:0] shift_phase(input quarter_t q);
    case (q)
      Q_0:     return C_PH_SHIFT_Q0;
      Q_1:     return C_PH_SHIFT_Q1;
      default: return C_PH_SHIFT_Q23;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ccd_clock_generator_phase_seq.sv
`default_nettype none
// ============================================================================
// Module      : ccd_phase_seq
// Description : Pixel-period sequencer for the SHIFT state. A PHASE_CYC
//               prescaler advances a quarter counter (q0..q3), which in turn
//               advances the pixel index (0..N_PIXELS-1). All counters are
//               held at zero while i_en is low.
// Ports       : i_clk, i_rst        clock / async active-high reset
//               i_en                high only while the FSM is in SHIFT
//               o_quarter           current quarter of the pixel period
//               o_sample            last clock of q1
//               o_last              last clock of q3 of the last pixel
//               o_pixel_idx         current pixel period index
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module ccd_phase_seq
  import ccd_gen_pkg::*;
#(
  parameter int unsigned N_PIXELS  = 2052,
  parameter int unsigned PHASE_CYC = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  output quarter_t                    o_quarter,
  output logic                        o_sample,
  output logic                        o_last,
  output logic [$clog2(N_PIXELS)-1:0] o_pixel_idx
);

  localparam int PIX_W = $clog2(N_PIXELS);
  // A one-clock quarter still needs a 1-bit prescaler register.
  localparam int PRE_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;

  localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(PHASE_CYC - 1);
  localparam logic [PIX_W-1:0] C_PIX_LAST = PIX_W'(N_PIXELS - 1);

  logic [PRE_W-1:0] r_presc;
  quarter_t         r_quarter;
  logic [PIX_W-1:0] r_pixel;

  logic       w_presc_last;
  logic       w_pix_last;
  logic [1:0] w_q_inc;

  assign w_presc_last = (r_presc == C_PRE_LAST);
  assign w_pix_last   = (r_pixel == C_PIX_LAST);
  assign w_q_inc      = r_quarter + 2'd1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc   <= '0;
      r_quarter <= Q_0;
      r_pixel   <= '0;
    end else if (!i_en) begin
      r_presc   <= '0;
      r_quarter <= Q_0;
      r_pixel   <= '0;
    end else if (w_presc_last) begin
      r_presc   <= '0;
      // Quarter counter wraps naturally every 4 quarters.
      r_quarter <= quarter_t'(w_q_inc);
      if (r_quarter == Q_3) begin
        r_pixel <= w_pix_last ? '0 : r_pixel + 1'b1;
      end
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign o_quarter   = r_quarter;
  assign o_sample    = i_en && (r_quarter == Q_1) && w_presc_last;
  assign o_last      = i_en && (r_quarter == Q_3) && w_presc_last && w_pix_last;
  assign o_pixel_idx = r_pixel;

endmodule
`default_nettype wire

// File: rtl/ccd_clock_generator.sv
`default_nettype none
// ============================================================================
// Module      : ccd_clock_generator
// Description : Linear-CCD clock generator. Sequences IDLE -> PRECHARGE ->
//               SHIFT -> HOLD -> TRANSFER, in one-shot or continuous mode,
//               with registered phase outputs, ADC sample strobe, pixel index
//               and busy / frame-done status.
// Ports       : i_clk, i_rst        clock / async active-high reset
//               i_enable            low forces IDLE and clears everything
//               i_continuous        free-running frames when high
//               i_start             one-shot frame trigger (IDLE only)
//               i_f_select          integration-time select
//               o_phi_p/r/l1/l2     CCD clocks
//               o_sample            ADC strobe, o_pixel_idx valid with it
//               o_busy              not in IDLE
//               o_frame_done        final TRANSFER cycle
//               o_frame_cnt         completed frames (CCDGEN_FRAME_CNT_EN)
// Build macro : CCDGEN_FRAME_CNT_EN adds the 16-bit frame counter port.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module ccd_clock_generator
  import ccd_gen_pkg::*;
#(
  parameter int unsigned N_PIXELS    = 2052,
  parameter int unsigned PHASE_CYC   = 1,
  parameter int unsigned PHI_P_WIDTH = 18,
  parameter int unsigned MIN_INT     = 32'h1009,
  parameter int unsigned STEP        = 32'h5FA4,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_enable,
  input  logic                        i_continuous,
  input  logic                        i_start,
  input  logic [SEL_W-1:0]            i_f_select,
  output logic                        o_phi_p,
  output logic                        o_phi_r,
  output logic                        o_phi_l1,
  output logic                        o_phi_l2,
  output logic                        o_sample,
  output logic [$clog2(N_PIXELS)-1:0] o_pixel_idx,
  output logic                        o_busy,
  output logic                        o_frame_done
`ifdef CCDGEN_FRAME_CNT_EN
  ,
  output logic [15:0]                 o_frame_cnt
`endif
);

  localparam int PIX_W = $clog2(N_PIXELS);
  localparam int C_WW  = CNT_W + SEL_W;

  localparam logic [CNT_W-1:0] C_PRE_LAST  = CNT_W'(PHI_P_WIDTH);
  localparam logic [CNT_W-1:0] C_XFER_LAST = CNT_W'(4 * PHI_P_WIDTH - 1);
  localparam logic [C_WW-1:0]  C_SAT       = C_WW'({CNT_W{1'b1}});

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W:0]   w_cnt_inc;
  logic [SEL_W-1:0] r_f_sel;
  logic             w_done;

  logic [C_WW-1:0]  w_tint_wide;
  logic [CNT_W-1:0] w_tint;
  logic             w_hold_last;

  logic             w_seq_en;
  quarter_t         w_quarter;
  logic             w_seq_sample;
  logic             w_seq_last;
  logic [PIX_W-1:0] w_seq_idx;

  logic [3:0]       w_phase;
  logic [3:0]       r_phase;
  logic             r_sample;
  logic [PIX_W-1:0] r_pixel_idx;
  logic             r_busy;
  logic             r_frame_done;

  assign w_seq_en = (r_state == ST_SHIFT) && i_enable;

  ccd_phase_seq #(
    .N_PIXELS  (N_PIXELS),
    .PHASE_CYC (PHASE_CYC)
  ) u_phase_seq (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (w_seq_en),
    .o_quarter   (w_quarter),
    .o_sample    (w_seq_sample),
    .o_last      (w_seq_last),
    .o_pixel_idx (w_seq_idx)
  );

  // Integration length computed wide enough that it cannot wrap, then
  // clamped to the largest value the timing counter can reach.
  assign w_tint_wide = C_WW'(MIN_INT) + C_WW'(r_f_sel) * C_WW'(STEP);
  assign w_tint      = (w_tint_wide > C_SAT) ? {CNT_W{1'b1}} : w_tint_wide[CNT_W-1:0];
  assign w_cnt_inc   = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  // ">=" rather than "==" so a zero-length request still leaves HOLD.
  assign w_hold_last = (w_cnt_inc >= {1'b0, w_tint});

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_continuous || i_start) w_state_next = ST_PRECHARGE;
      end
      ST_PRECHARGE: begin
        if (r_cnt == C_PRE_LAST) w_state_next = ST_SHIFT;
        else                     w_cnt_next   = w_cnt_inc[CNT_W-1:0];
      end
      ST_SHIFT: begin
        if (w_seq_last) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_hold_last) w_state_next = ST_TRANSFER;
        else             w_cnt_next   = w_cnt_inc[CNT_W-1:0];
      end
      ST_TRANSFER: begin
        if (r_cnt == C_XFER_LAST) begin
          w_done       = 1'b1;
          w_state_next = i_continuous ? ST_SHIFT : ST_IDLE;
        end else begin
          w_cnt_next = w_cnt_inc[CNT_W-1:0];
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // Dropping enable abandons the frame: no frame-done for a partial frame.
    if (!i_enable) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
      w_done       = 1'b0;
    end
  end

  always_comb begin
    w_phase = C_PH_IDLE;
    case (r_state)
      ST_PRECHARGE, ST_TRANSFER: w_phase = C_PH_GATE;
      ST_SHIFT:                  w_phase = shift_phase(w_quarter);
      default:                   w_phase = C_PH_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_f_sel <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // Latched once per frame on SHIFT entry, so HOLD uses a stable value.
      if (!i_enable) begin
        r_f_sel <= '0;
      end else if ((w_state_next == ST_SHIFT) && (r_state != ST_SHIFT)) begin
        r_f_sel <= i_f_select;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase      <= C_PH_IDLE;
      r_sample     <= 1'b0;
      r_pixel_idx  <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (!i_enable) begin
      r_phase      <= C_PH_IDLE;
      r_sample     <= 1'b0;
      r_pixel_idx  <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_phase      <= w_phase;
      r_sample     <= w_seq_sample;
      r_pixel_idx  <= w_seq_idx;
      r_busy       <= (r_state != ST_IDLE);
      r_frame_done <= w_done;
    end
  end

  assign o_phi_p      = r_phase[3];
  assign o_phi_r      = r_phase[2];
  assign o_phi_l1     = r_phase[1];
  assign o_phi_l2     = r_phase[0];
  assign o_sample     = r_sample;
  assign o_pixel_idx  = r_pixel_idx;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;

`ifdef CCDGEN_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Counts alongside o_frame_done; wraps 16'hFFFF -> 0 naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_frame_cnt <= '0;
    end else if (!i_enable) begin
      r_frame_cnt <= '0;
    end else if (w_done) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`else
  // Frame counter not present in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_ccd_clock_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccd_clock_generator
// Description : Directed self-checking bench for ccd_clock_generator.
//               Small geometry (4 pixels, 2-clock phi_p base, MIN_INT=10,
//               STEP=5) on the main instance; a second instance uses
//               PHASE_CYC=3. Monitors measure run lengths of each output
//               pattern and the position of strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccd_clock_generator;

  localparam int C_IDLE  = 0;
  localparam int C_PRE   = 1;
  localparam int C_SHIFT = 2;
  localparam int C_HOLD  = 3;
  localparam int C_XFER  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance, PHASE_CYC = 1
  logic       enable = 1'b0, continuous = 1'b0, start = 1'b0;
  logic [3:0] fsel = 4'd0;
  logic       phi_p, phi_r, phi_l1, phi_l2, sample, busy, done;
  logic [1:0] pixel_idx;

  // Second instance, PHASE_CYC = 3
  logic       en3 = 1'b0, cont3 = 1'b0, start3 = 1'b0;
  logic [3:0] fsel3 = 4'd0;
  logic       p3, r3, l13, l23, sample3, busy3, done3;
  logic [1:0] idx3;

`ifdef CCDGEN_FRAME_CNT_EN
  logic [15:0] frame_cnt, frame_cnt3;
`endif

  ccd_clock_generator #(
    .N_PIXELS(4), .PHASE_CYC(1), .PHI_P_WIDTH(2), .MIN_INT(10), .STEP(5),
    .SEL_W(4), .CNT_W(32)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_continuous(continuous),
    .i_start(start), .i_f_select(fsel),
    .o_phi_p(phi_p), .o_phi_r(phi_r), .o_phi_l1(phi_l1), .o_phi_l2(phi_l2),
    .o_sample(sample), .o_pixel_idx(pixel_idx), .o_busy(busy),
    .o_frame_done(done)
`ifdef CCDGEN_FRAME_CNT_EN
    , .o_frame_cnt(frame_cnt)
`endif
  );

  ccd_clock_generator #(
    .N_PIXELS(4), .PHASE_CYC(3), .PHI_P_WIDTH(2), .MIN_INT(10), .STEP(5),
    .SEL_W(4), .CNT_W(32)
  ) dut3 (
    .i_clk(clk), .i_rst(rst), .i_enable(en3), .i_continuous(cont3),
    .i_start(start3), .i_f_select(fsel3),
    .o_phi_p(p3), .o_phi_r(r3), .o_phi_l1(l13), .o_phi_l2(l23),
    .o_sample(sample3), .o_pixel_idx(idx3), .o_busy(busy3),
    .o_frame_done(done3)
`ifdef CCDGEN_FRAME_CNT_EN
    , .o_frame_cnt(frame_cnt3)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- main-instance monitor ----------------
  int          cyc = 0;
  int          cur_cls = C_IDLE;
  int          cur_len = 0;
  int          run_len [5];
  int          x2s = 0;
  int          sample_cnt = 0, bad_sample = 0;
  int          done_cnt = 0, bad_done = 0;
  int          last_done = 0, prev_done = 0;
  int          viol = 0;
  logic [7:0]  idx_log = '0;
  logic [15:0] shift_pat = '0;

  always @(negedge clk) begin : mon_main
    logic [3:0] v;
    int         cls;
    cyc++;
    v = {phi_p, phi_r, phi_l1, phi_l2};
    if (!busy)             cls = C_IDLE;
    else if (v == 4'b0000) cls = C_HOLD;
    else if (v == 4'b1101) cls = (cur_cls == C_HOLD || cur_cls == C_XFER) ? C_XFER : C_PRE;
    else                   cls = C_SHIFT;
    if ((phi_l1 && phi_l2) || (phi_l1 && phi_p)) viol++;
    if (cls == cur_cls) begin
      cur_len++;
    end else begin
      run_len[cur_cls] = cur_len;
      if (cur_cls == C_XFER && cls == C_SHIFT) x2s++;
      cur_len = 1;
      cur_cls = cls;
    end
    if (cls == C_SHIFT && cur_len <= 4) shift_pat = {shift_pat[11:0], v};
    if (sample) begin
      sample_cnt++;
      idx_log = {idx_log[5:0], pixel_idx};
      if (v != 4'b0001) bad_sample++;
    end
    if (done) begin
      done_cnt++;
      prev_done = last_done;
      last_done = cyc;
      if (v != 4'b1101) bad_done++;
    end
  end

  // ---------------- PHASE_CYC=3 monitor ----------------
  int          off3 = 0, shift3_len = 0, s3_cnt = 0, s3_bad = 0, done3_cnt = 0;
  logic        in3 = 1'b0;
  logic [47:0] pat3 = '0;
  logic [7:0]  idx3_log = '0;

  always @(negedge clk) begin : mon_3
    logic [3:0] v3;
    v3 = {p3, r3, l13, l23};
    if ((l13 && l23) || (l13 && p3)) viol++;
    if (busy3 && !p3 && v3 != 4'b0000) begin
      if (sample3) begin
        s3_cnt++;
        idx3_log = {idx3_log[5:0], idx3};
        if ((off3 % 12) != 5) s3_bad++;
      end
      if (off3 < 12) pat3 = {pat3[43:0], v3};
      off3++;
      in3 = 1'b1;
    end else begin
      if (sample3) s3_bad++;
      if (in3) shift3_len = off3;
      in3  = 1'b0;
      off3 = 0;
    end
    if (done3) done3_cnt++;
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_cls(input int cls, input int budget, input string tag);
    int k = 0;
    while (cur_cls != cls && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(cur_cls == cls), 64'd1);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(done_cnt >= target), 64'd1);
  endtask

  function automatic logic [63:0] outs();
    return 64'({phi_p, phi_r, phi_l1, phi_l2, sample, busy, done, pixel_idx});
  endfunction

  initial begin
    int d0, s0, x0, k;

    // Reset
    tick(2);
    chk("reset_outs", outs(), 64'd0);
    rst = 1'b0;
    tick(2);
    chk("post_reset_outs", outs(), 64'd0);

    // Single frame, f_select = 2, with a stray start mid-frame
    enable = 1'b1; fsel = 4'd2; start = 1'b1;
    d0 = done_cnt; s0 = sample_cnt;
    tick(1);
    start = 1'b0;
    wait_cls(C_SHIFT, 20, "s1_reach_shift");
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(d0 + 1, 100, "s1_done");
    tick(3);
    chk("s1_pre_len",   64'(run_len[C_PRE]),   64'd3);
    chk("s1_shift_len", 64'(run_len[C_SHIFT]), 64'd16);
    chk("s1_hold_len",  64'(run_len[C_HOLD]),  64'd20);
    chk("s1_xfer_len",  64'(run_len[C_XFER]),  64'd8);
    chk("s1_samples",   64'(sample_cnt - s0),  64'd4);
    chk("s1_idx_seq",   64'(idx_log),          64'h1B);
    chk("s1_shift_pat", 64'(shift_pat),        64'h5122);
    chk("s1_bad_sample", 64'(bad_sample),      64'd0);
    chk("s1_bad_done",  64'(bad_done),         64'd0);
    chk("s1_busy_end",  64'(busy),             64'd0);
    tick(10);
    chk("s1_one_done",  64'(done_cnt - d0),    64'd1);
    chk("s1_idle_outs", outs(),                64'd0);

    // Continuous, f_select = 0
    fsel = 4'd0; continuous = 1'b1;
    d0 = done_cnt; x0 = x2s;
    wait_done(d0 + 3, 300, "s2_three_frames");
    tick(2);
    chk("s2_hold_len", 64'(run_len[C_HOLD]),     64'd10);
    chk("s2_period",   64'(last_done - prev_done), 64'd34);
    chk("s2_x2s",      64'(x2s - x0),            64'd3);

    // f_select change mid-frame only affects the next frame
    fsel = 4'd1;
    wait_done(d0 + 4, 100, "s2_frame4");
    chk("s2_f4_hold", 64'(run_len[C_HOLD]), 64'd10);
    wait_cls(C_HOLD, 40, "s2_f5_hold_reach");
    fsel = 4'd3;
    wait_done(d0 + 5, 100, "s2_frame5");
    chk("s2_f5_hold",   64'(run_len[C_HOLD]),       64'd15);
    chk("s2_f5_period", 64'(last_done - prev_done), 64'd39);
    wait_done(d0 + 6, 100, "s2_frame6");
    chk("s2_f6_hold",   64'(run_len[C_HOLD]),       64'd25);
    chk("s2_f6_period", 64'(last_done - prev_done), 64'd49);

    // Drop continuous mid-frame: frame completes, then IDLE
    continuous = 1'b0;
    wait_done(d0 + 7, 100, "s2_frame7");
    tick(3);
    chk("s2_f7_hold",  64'(run_len[C_HOLD]), 64'd25);
    chk("s2_idle_busy", 64'(busy),           64'd0);
    tick(10);
    chk("s2_no_extra", 64'(done_cnt - d0),   64'd7);

    // Enable low mid-SHIFT
    start = 1'b1; d0 = done_cnt;
    tick(1);
    start = 1'b0;
    wait_cls(C_SHIFT, 20, "s3_reach_shift");
    tick(2);
    enable = 1'b0;
    tick(1);
    chk("s3_outs_zero", outs(), 64'd0);
    enable = 1'b1;
    tick(30);
    chk("s3_no_done", 64'(done_cnt - d0), 64'd0);
    chk("s3_idle",    64'(busy),          64'd0);

    // Asynchronous reset mid-HOLD
    start = 1'b1; d0 = done_cnt;
    tick(1);
    start = 1'b0;
    wait_cls(C_HOLD, 40, "s4_reach_hold");
    chk("s4_busy_in_hold", 64'(busy), 64'd1);
    #1 rst = 1'b1;
    #1 chk("s4_async_rst", outs(), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(40);
    chk("s4_no_done", 64'(done_cnt - d0), 64'd0);
    chk("s4_idle",    64'(busy),          64'd0);

    // PHASE_CYC = 3 instance, single frame
    en3 = 1'b1; start3 = 1'b1;
    tick(1);
    start3 = 1'b0;
    k = 0;
    while (done3_cnt < 1 && k < 300) begin
      tick(1);
      k++;
    end
    chk("s5_done", 64'(done3_cnt), 64'd1);
    tick(2);
    chk("s5_shift_len", 64'(shift3_len), 64'd48);
    chk("s5_samples",   64'(s3_cnt),     64'd4);
    chk("s5_sample_pos", 64'(s3_bad),    64'd0);
    chk("s5_pattern",   64'(pat3),       64'h555111222222);
    chk("s5_idx_seq",   64'(idx3_log),   64'h1B);

`ifdef CCDGEN_FRAME_CNT_EN
    // Frame counter: 5 continuous frames, then cleared by enable low
    enable = 1'b0;
    tick(1);
    chk("s6_cnt_clear0", 64'(frame_cnt), 64'd0);
    enable = 1'b1; continuous = 1'b1; d0 = done_cnt;
    wait_done(d0 + 5, 400, "s6_five_frames");
    chk("s6_cnt5", 64'(frame_cnt), 64'd5);
    enable = 1'b0; continuous = 1'b0;
    tick(1);
    chk("s6_cnt_clear", 64'(frame_cnt), 64'd0);
    enable = 1'b1;
`endif

    chk("phase_overlap", 64'(viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
